// File: rtl/board_if_pkg.sv
// rtl/board_if_pkg.sv - shared state encoding and counter sizing for the debouncer
package board_if_pkg;

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} deb_state_t;

    // Width of a counter that must hold values 0..max; never narrower than one bit.
    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - synchronised button inputs and debounced event outputs
interface button_debouncer_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] sync_in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] held;

    modport master (output sync_in, input level, rise, fall, held);
    modport slave  (input sync_in, output level, rise, fall, held);
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - single-channel debounce FSM with edge and long-press pulses
module debounce_channel
    import board_if_pkg::*;
#(
    parameter int   STABLE_CYCLES = 500_000,
    parameter int   HOLD_CYCLES   = 50_000_000,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic held
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    deb_state_t      state;
    logic [CW-1:0]   cnt;
    logic [HW-1:0]   hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
            cnt      <= '0;
            hold_cnt <= '0;
            level    <= RESET_LEVEL;
            rise     <= 1'b0;
            fall     <= 1'b0;
            held     <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            held <= 1'b0;

            // Hold timer runs while the committed level is high; a fall commit below overrides it.
            if ((state == STABLE_HI || state == WAIT_LO) && HOLD_CYCLES > 0 && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt + 1'b1 == HOLD_MAX)
                    held <= 1'b1;
            end

            case (state)
                STABLE_LO: begin
                    if (sync_in) begin
                        state <= WAIT_HI;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync_in) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= STABLE_HI;
                        level    <= 1'b1;
                        rise     <= 1'b1;
                        cnt      <= '0;
                        hold_cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync_in) begin
                        state <= WAIT_LO;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LO: begin
                    if (sync_in) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= STABLE_LO;
                        level    <= 1'b0;
                        fall     <= 1'b1;
                        cnt      <= '0;
                        hold_cnt <= '0;
                        held     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - N_CH independent debounce channels
module button_debouncer
    import board_if_pkg::*;
#(
    parameter int   N_CH          = 4,
    parameter int   STABLE_CYCLES = 500_000,
    parameter int   HOLD_CYCLES   = 50_000_000,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    button_debouncer_if.slave   bus
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .RESET_LEVEL   (RESET_LEVEL)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .sync_in (bus.sync_in[i]),
            .level   (bus.level[i]),
            .rise    (bus.rise[i]),
            .fall    (bus.fall[i]),
            .held    (bus.held[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed scoreboard bench for button_debouncer
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst_n;

    button_debouncer_if #(.N_CH(2)) bus ();

    button_debouncer #(
        .N_CH          (2),
        .STABLE_CYCLES (4),
        .HOLD_CYCLES   (10),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] v;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [7:0] observed();
        return {bus.level, bus.rise, bus.fall, bus.held};
    endfunction

    task automatic check_now(input logic [7:0] exp, input string tag);
        logic [7:0] obs;
        obs = observed();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed lvl/rise/fall/held=%b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one input sample, queue the expected post-edge outputs, and score after the edge.
    task automatic step(input logic [1:0] din, input logic [1:0] lv, input logic [1:0] rs,
                        input logic [1:0] fl, input logic [1:0] hd, input string tag);
        exp_t e;
        bus.sync_in = din;
        e.v   = {lv, rs, fl, hd};
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_now(e.v, e.tag);
    endtask

    task automatic quiet(input int n, input logic [1:0] din, input logic [1:0] lv, input string tag);
        for (int i = 0; i < n; i++)
            step(din, lv, 2'b00, 2'b00, 2'b00, tag);
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        bus.sync_in = 2'b00;
        #3;
        check_now(8'h00, "reset_state");
        #14;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bouncy press never reaches four consecutive samples.
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_a");
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_b");
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_c");
        step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_d");
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_e");
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_f");
        step(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_g");
        step(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_h");

        // Clean press: rise on the fourth sample, held ten cycles later, once.
        quiet(3, 2'b01, 2'b00, "press_wait");
        step(2'b01, 2'b01, 2'b01, 2'b00, 2'b00, "press_rise");
        quiet(9, 2'b01, 2'b01, "press_hold_wait");
        step(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, "press_held");
        quiet(4, 2'b01, 2'b01, "press_no_repeat");
        quiet(3, 2'b00, 2'b01, "release_wait");
        step(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "release_fall");
        quiet(1, 2'b00, 2'b00, "release_after");

        // Second press with a 3-cycle dropout: no fall, held still counts from the rise.
        quiet(3, 2'b01, 2'b00, "press2_wait");
        step(2'b01, 2'b01, 2'b01, 2'b00, 2'b00, "press2_rise");
        quiet(2, 2'b01, 2'b01, "press2_hi");
        quiet(3, 2'b00, 2'b01, "press2_dropout");
        quiet(4, 2'b01, 2'b01, "press2_back");
        step(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, "press2_held");
        quiet(10, 2'b01, 2'b01, "press2_long");
        quiet(3, 2'b00, 2'b01, "press2_release_wait");
        step(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "press2_fall");

        // Reset asserted while ch0 is three samples into WAIT_HI and ch1 is high.
        quiet(3, 2'b10, 2'b00, "ch1_wait");
        step(2'b10, 2'b10, 2'b10, 2'b00, 2'b00, "ch1_rise");
        quiet(3, 2'b11, 2'b10, "ch0_wait_cnt3");
        #2;
        rst_n = 1'b0;
        #1;
        check_now(8'h00, "async_reset");
        #2;
        rst_n = 1'b1;

        // Both inputs still high: a fresh four-sample run, committing together.
        quiet(3, 2'b11, 2'b00, "post_reset_wait");
        step(2'b11, 2'b11, 2'b11, 2'b00, 2'b00, "dual_rise");
        quiet(1, 2'b11, 2'b11, "dual_hi");
        quiet(3, 2'b01, 2'b11, "ch1_release_wait");
        step(2'b01, 2'b01, 2'b00, 2'b10, 2'b00, "ch1_fall_only");
        quiet(4, 2'b01, 2'b01, "ch0_alone");
        step(2'b01, 2'b01, 2'b00, 2'b00, 2'b01, "ch0_held_only");
        quiet(2, 2'b01, 2'b01, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
